lotr_mem_dump: RTL and testbench
================================

Name: lotr_mem_dump

Overview:
- Hardware memory-snapshot reader for a tile's data memory, used on FPGA builds where no simulator backdoor exists.
- On a start pulse it reads a word-aligned address range through a single-port read interface with 1-cycle read latency.
- It serializes each word as bytes, MSB first, on a valid/ready byte stream toward the host link (UART/JTAG bridge).
- It sits beside d_mem_wrap and borrows the read port while the cores are held idle.

Parameters:
- ADDR_W, 16, byte-address width of the data memory.
- MEM_OFFSET, 32'h0040_0000, base added to the emitted address header (header feature only).

Ports:
- QClk  in  1  clock.
- RstQnnnL  in  1  asynchronous active-low reset.
- StartQnnnH  in  1  single-cycle start request; sampled only in IDLE.
- AbortQnnnH  in  1  abort the current dump.
- StartAddrQnnnH  in  ADDR_W  first byte address, inclusive.
- EndAddrQnnnH  in  ADDR_W  last byte address, exclusive.
- RdEnQnnnH  out  1  memory read strobe.
- RdAddrQnnnH  out  ADDR_W  word-aligned read address.
- RdDataQnnnH  in  32  read data, valid the cycle after RdEnQnnnH.
- TxValidQnnnH  out  1  byte valid.
- TxDataQnnnH  out  8  byte.
- TxReadyQnnnH  in  1  sink ready.
- BusyQnnnH  out  1  high in every state except IDLE.
- DoneQnnnH  out  1  one-cycle pulse at the end of a dump.
- ErrQnnnH  out  1  sticky: bad range or abort; cleared by the next accepted start.
- WordCntQnnnH  out  ADDR_W-2  words fully sent in the current or last dump.

Behaviour:
- Reset: all outputs 0; state IDLE; internal address and byte counters 0.
- States: IDLE -> CHECK -> RD_REQ -> RD_WAIT -> SEND -> (RD_REQ | DONE) -> IDLE.
- IDLE: StartQnnnH=1 latches both addresses, clears ErrQnnnH and WordCntQnnnH, goes to CHECK. StartQnnnH in any other state is ignored.
- CHECK:
  - If either address has bits [1:0]!=0, or Start>End: set ErrQnnnH, go to DONE, no reads.
  - If Start==End: go to DONE, no reads, ErrQnnnH stays 0.
  - Otherwise go to RD_REQ.
- RD_REQ: RdEnQnnnH=1 for exactly one cycle, RdAddrQnnnH=current address.
- RD_WAIT: captures RdDataQnnnH into a 32-bit shift buffer at the end of the cycle. Byte index resets to 0.
- SEND:
  - TxValidQnnnH=1 and TxDataQnnnH=buffer[31:24].
  - On TxValid&TxReady the buffer shifts left 8 and the byte index increments.
  - TxDataQnnnH and TxValidQnnnH stay stable while TxReadyQnnnH=0.
  - After byte 3 is accepted: WordCnt+1, address+4. If the new address == End go to DONE, else go to RD_REQ.
- Latency: Start at cycle N -> RdEn at N+2 -> first TxValid at N+4. With TxReady held high, each word takes 6 cycles (RD_REQ + RD_WAIT + 4 SEND).
- DONE: DoneQnnnH=1 for one cycle, then IDLE. BusyQnnnH=0 in IDLE only.
- Abort, highest priority, in any non-IDLE state:
  - Takes effect at the next edge: state goes to DONE, ErrQnnnH=1.
  - TxValidQnnnH drops immediately, even mid-word; the sink must tolerate a truncated word.
  - WordCntQnnnH keeps its count of completed words.
- Abort and Start in the same cycle while in IDLE: Start wins, Abort is ignored.
- Address arithmetic is ADDR_W wide. End is exclusive, so wrap past 2^ADDR_W cannot occur for legal ranges.
- Reset asserted mid-dump: returns to IDLE asynchronously. TxValidQnnnH and RdEnQnnnH go 0 immediately. DoneQnnnH does not pulse.

Optional Feature:
- Macro LOTR_MEM_DUMP_ADDR_HDR_EN.
- When defined: each word is preceded by 4 header bytes, (MEM_OFFSET + address) MSB first. SEND therefore emits 8 bytes per word; the header occupies SEND byte indices 0-3 and data 4-7. Per-word cost becomes 10 cycles at full throughput.
- When undefined: data bytes only, 4 per word. MEM_OFFSET is unused.

Test Plan:
- Range 0x0000-0x0008 with mem[0]=32'h1122_3344 and mem[4]=32'hAABB_CCDD, TxReady=1 -> bytes 11,22,33,44,AA,BB,CC,DD; first TxValid 4 cycles after Start; Done pulses once; WordCnt=2; Err=0.
- Same range with TxReady toggled 1/0 every cycle -> identical byte sequence; TxData stable while stalled; exactly 2 RdEn pulses.
- Start=0x0010, End=0x0010 -> Done 2 cycles after Start, no RdEn, no TxValid, Err=0. Start=0x0012 -> Err=1, no reads.
- Start=0x0020 > End=0x0010 -> Err=1, Done pulse, WordCnt=0. A following legal start clears Err.
- Abort raised during the 3rd byte of word 1 in a 4-word dump -> TxValid low next cycle, Done pulse, Err=1, WordCnt=1. Reset asserted mid-word -> all outputs 0 immediately, no Done.
- With LOTR_MEM_DUMP_ADDR_HDR_EN, range 0x0004-0x0008, MEM_OFFSET=0x0040_0000, mem[4]=32'hDEAD_BEEF -> bytes 00,40,00,04,DE,AD,BE,EF.

Source files
------------

// File: rtl/lotr_mem_dump.sv
// ---------------------------------------------------------------------------
// lotr_mem_dump
//
// Hardware memory-snapshot reader. On a start pulse it walks a word-aligned
// byte-address range [StartAddr, EndAddr) through a single-port read port
// with one cycle of read latency. Each word is sent MSB first as four bytes
// on a valid/ready byte stream toward the host link.
//
// Optional feature (macro LOTR_MEM_DUMP_ADDR_HDR_EN):
//   Each word is preceded by a 4-byte header (MEM_OFFSET + address), MSB
//   first. SEND then emits 8 bytes per word: header on byte indices 0-3 and
//   data on indices 4-7. The MEM_OFFSET parameter exists only in that build.
//
// Ports:
//   QClk            clock
//   RstQnnnL        asynchronous active-low reset
//   StartQnnnH      start request, sampled only in IDLE
//   AbortQnnnH      abort the running dump (ignored in IDLE)
//   StartAddrQnnnH  first byte address, inclusive
//   EndAddrQnnnH    last byte address, exclusive
//   RdEnQnnnH       memory read strobe
//   RdAddrQnnnH     word-aligned read address
//   RdDataQnnnH     read data, valid the cycle after RdEnQnnnH
//   TxValidQnnnH    byte valid
//   TxDataQnnnH     byte
//   TxReadyQnnnH    sink ready
//   BusyQnnnH       high in every state except IDLE
//   DoneQnnnH       one-cycle pulse at the end of a dump
//   ErrQnnnH        sticky: bad range or abort, cleared by the next start
//   WordCntQnnnH    words fully sent in the current or last dump
// ---------------------------------------------------------------------------
module lotr_mem_dump #(
    parameter int ADDR_W = 16
`ifdef LOTR_MEM_DUMP_ADDR_HDR_EN
    ,
    parameter logic [31:0] MEM_OFFSET = 32'h0040_0000
`endif
) (
    input  logic              QClk,
    input  logic              RstQnnnL,
    input  logic              StartQnnnH,
    input  logic              AbortQnnnH,
    input  logic [ADDR_W-1:0] StartAddrQnnnH,
    input  logic [ADDR_W-1:0] EndAddrQnnnH,
    output logic              RdEnQnnnH,
    output logic [ADDR_W-1:0] RdAddrQnnnH,
    input  logic [31:0]       RdDataQnnnH,
    output logic              TxValidQnnnH,
    output logic [7:0]        TxDataQnnnH,
    input  logic              TxReadyQnnnH,
    output logic              BusyQnnnH,
    output logic              DoneQnnnH,
    output logic              ErrQnnnH,
    output logic [ADDR_W-3:0] WordCntQnnnH
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        SEND,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       shift_buf;
    logic [2:0]        byte_idx;
    logic              err;
    logic [ADDR_W-3:0] word_cnt;

    logic              range_bad;
    logic              range_empty;
    logic              abortable;
    logic              send_valid;
    logic              byte_fire;
    logic              last_byte;
    logic              data_byte;
    logic [7:0]        tx_byte;

    // Range checks run on the latched addresses while in CHECK.
    assign range_bad   = (cur_addr[1:0] != 2'b00) || (end_addr[1:0] != 2'b00) ||
                         (cur_addr > end_addr);
    assign range_empty = (cur_addr == end_addr);
    assign next_addr   = cur_addr + ADDR_W'(4);

    // Abort only has meaning while a dump is actually in progress; in DONE
    // the dump is already finishing and a second Done pulse must not occur.
    assign abortable = (state == CHECK) || (state == RD_REQ) ||
                       (state == RD_WAIT) || (state == SEND);

    // Valid is masked by Abort so the stream stops in the very cycle the
    // abort is raised and no further byte can be handed over.
    assign send_valid = (state == SEND) && !AbortQnnnH;
    assign byte_fire  = send_valid && TxReadyQnnnH;

`ifdef LOTR_MEM_DUMP_ADDR_HDR_EN
    logic [31:0] hdr_word;

    assign hdr_word  = MEM_OFFSET + 32'(cur_addr);
    assign data_byte = byte_idx[2];
    assign last_byte = (byte_idx == 3'd7);

    // Header bytes come straight from the address; data bytes from the
    // shift buffer, which only moves on data-byte handshakes.
    always_comb begin
        tx_byte = shift_buf[31:24];
        if (!byte_idx[2]) begin
            case (byte_idx[1:0])
                2'd0:    tx_byte = hdr_word[31:24];
                2'd1:    tx_byte = hdr_word[23:16];
                2'd2:    tx_byte = hdr_word[15:8];
                default: tx_byte = hdr_word[7:0];
            endcase
        end
    end
`else
    assign data_byte = 1'b1;
    assign last_byte = (byte_idx == 3'd3);
    assign tx_byte   = shift_buf[31:24];
`endif

    assign RdAddrQnnnH  = cur_addr;
    assign TxDataQnnnH  = send_valid ? tx_byte : 8'h00;
    assign ErrQnnnH     = err;
    assign WordCntQnnnH = word_cnt;

    // State register.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs. Abort overrides every transition of
    // an in-progress dump and forces DONE.
    always_comb begin
        state_next   = state;
        RdEnQnnnH    = 1'b0;
        TxValidQnnnH = send_valid;
        DoneQnnnH    = 1'b0;
        BusyQnnnH    = (state != IDLE);

        case (state)
            IDLE: begin
                if (StartQnnnH) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (range_bad || range_empty) begin
                    state_next = DONE;
                end else begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                RdEnQnnnH  = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = SEND;
            end
            SEND: begin
                if (byte_fire && last_byte) begin
                    state_next = (next_addr == end_addr) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                DoneQnnnH  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abortable && AbortQnnnH) begin
            state_next = DONE;
        end
    end

    // Datapath: latched range, current address, shift buffer, byte index,
    // sticky error and completed-word counter.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            cur_addr  <= '0;
            end_addr  <= '0;
            shift_buf <= '0;
            byte_idx  <= '0;
            err       <= 1'b0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartQnnnH) begin
                        cur_addr <= StartAddrQnnnH;
                        end_addr <= EndAddrQnnnH;
                        err      <= 1'b0;
                        word_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (range_bad) begin
                        err <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    shift_buf <= RdDataQnnnH;
                    byte_idx  <= '0;
                end
                SEND: begin
                    if (byte_fire) begin
                        if (data_byte) begin
                            shift_buf <= {shift_buf[23:0], 8'h00};
                        end
                        if (last_byte) begin
                            word_cnt <= word_cnt + (ADDR_W-2)'(1);
                            cur_addr <= next_addr;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (abortable && AbortQnnnH) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lotr_mem_dump.sv
// ---------------------------------------------------------------------------
// tb_lotr_mem_dump
//
// Self-checking bench for lotr_mem_dump. A small memory model answers the
// read port one cycle after RdEn. Expected byte streams, word counts and
// error flags come from a range-walking reference function built on the
// memory array. Build with LOTR_MEM_DUMP_ADDR_HDR_EN defined to exercise
// the address-header variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lotr_mem_dump;

`ifdef LOTR_MEM_DUMP_ADDR_HDR_EN
    localparam int BPW = 8;
`else
    localparam int BPW = 4;
`endif

    logic        QClk;
    logic        RstQnnnL;
    logic        StartQnnnH;
    logic        AbortQnnnH;
    logic [15:0] StartAddrQnnnH;
    logic [15:0] EndAddrQnnnH;
    logic        RdEnQnnnH;
    logic [15:0] RdAddrQnnnH;
    logic [31:0] RdDataQnnnH;
    logic        TxValidQnnnH;
    logic [7:0]  TxDataQnnnH;
    logic        TxReadyQnnnH;
    logic        BusyQnnnH;
    logic        DoneQnnnH;
    logic        ErrQnnnH;
    logic [13:0] WordCntQnnnH;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] obs_bytes[$];
    logic [7:0] exp_bytes[$];
    int         exp_words;
    logic       exp_err;

    int         rd_cnt;
    int         valid_cnt;
    int         first_valid_dly;
    int         done_cnt;
    int         done_dly;
    int         abort_next_valid;
    logic [13:0] word_cnt_done;
    logic       err_done;
    logic       err_early;
    logic       busy_end;

    lotr_mem_dump #(.ADDR_W(16)) dut (
        .QClk           (QClk),
        .RstQnnnL       (RstQnnnL),
        .StartQnnnH     (StartQnnnH),
        .AbortQnnnH     (AbortQnnnH),
        .StartAddrQnnnH (StartAddrQnnnH),
        .EndAddrQnnnH   (EndAddrQnnnH),
        .RdEnQnnnH      (RdEnQnnnH),
        .RdAddrQnnnH    (RdAddrQnnnH),
        .RdDataQnnnH    (RdDataQnnnH),
        .TxValidQnnnH   (TxValidQnnnH),
        .TxDataQnnnH    (TxDataQnnnH),
        .TxReadyQnnnH   (TxReadyQnnnH),
        .BusyQnnnH      (BusyQnnnH),
        .DoneQnnnH      (DoneQnnnH),
        .ErrQnnnH       (ErrQnnnH),
        .WordCntQnnnH   (WordCntQnnnH)
    );

    // 100 MHz clock and a free-running cycle counter for latency checks.
    initial QClk = 1'b0;
    always #5 QClk = ~QClk;
    always @(posedge QClk) cyc <= cyc + 1;

    // Memory model: data appears the cycle after a read strobe; otherwise
    // the bus carries junk so a mistimed capture shows up.
    always @(posedge QClk) begin
        if (RdEnQnnnH) RdDataQnnnH <= mem[RdAddrQnnnH[9:2]];
        else           RdDataQnnnH <= $urandom;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: walk the range a word at a time and list the bytes the
    // host should receive.
    function automatic void build_expected(input logic [15:0] s, input logic [15:0] e);
        logic [31:0] w;
        logic [31:0] hdr;
        exp_bytes.delete();
        exp_words = 0;
        exp_err   = 1'b0;
        if (s[1:0] != 2'b00 || e[1:0] != 2'b00 || s > e) begin
            exp_err = 1'b1;
            return;
        end
        for (int a = int'(s); a < int'(e); a += 4) begin
            hdr = 32'h0040_0000 + 32'(a);
`ifdef LOTR_MEM_DUMP_ADDR_HDR_EN
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(hdr[8*b +: 8]);
`endif
            w = mem[a[9:2]];
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[8*b +: 8]);
            exp_words++;
        end
    endfunction

    task automatic compareBytes(input string tag);
        checkOutput({tag, "_count"}, obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), obs_bytes[i], exp_bytes[i]);
    endtask

    // Run one dump: pulse Start, drive TxReady per mode (0 high, 1 toggle,
    // 2 random with stray Start pulses while busy), optionally abort or reset
    // once a given number of bytes has been accepted, and record what the
    // DUT did each cycle (sampled on the falling edge).
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] e,
                                 input int ready_mode, input int abort_at,
                                 input int reset_at, input bit abort_with_start);
        int t0, cur, post, post_rst, abort_phase;
        bit finished, stall_prev, rst_done, rec_abort;
        logic [7:0] prev_data;
        t0 = 0; cur = 0; post = 0; post_rst = 0; abort_phase = 0;
        finished = 0; stall_prev = 0; rst_done = 0; rec_abort = 0; prev_data = 8'h00;
        obs_bytes.delete();
        rd_cnt = 0; valid_cnt = 0; first_valid_dly = -1; done_cnt = 0;
        done_dly = -1; abort_next_valid = -1;
        word_cnt_done = '1; err_done = 1'bx; err_early = 1'bx; busy_end = 1'bx;

        for (int n = 0; n < 600 && !finished; n++) begin
            @(posedge QClk); #1;
            if (n == 0) begin
                StartAddrQnnnH = s;
                EndAddrQnnnH   = e;
                StartQnnnH     = 1'b1;
                AbortQnnnH     = abort_with_start;
                t0 = cyc;
            end else begin
                StartQnnnH = 1'b0;
                AbortQnnnH = 1'b0;
                if (abort_phase == 1) abort_phase = 2;
                if (abort_at >= 0 && abort_phase == 0 &&
                    obs_bytes.size() == abort_at && TxValidQnnnH) begin
                    AbortQnnnH  = 1'b1;
                    abort_phase = 1;
                end
                if (ready_mode == 2 && BusyQnnnH && !DoneQnnnH &&
                    $urandom_range(0, 3) == 0) begin
                    StartQnnnH     = 1'b1;
                    StartAddrQnnnH = 16'($urandom);
                end
                if (rst_done) begin
                    post_rst++;
                    if (post_rst == 3) RstQnnnL = 1'b1;
                end
                if (reset_at >= 0 && !rst_done &&
                    obs_bytes.size() == reset_at && TxValidQnnnH) begin
                    RstQnnnL = 1'b0;
                    rst_done = 1;
                    #1;
                    checkOutput("rst_rden",    RdEnQnnnH,    0);
                    checkOutput("rst_txvalid", TxValidQnnnH, 0);
                    checkOutput("rst_txdata",  TxDataQnnnH,  0);
                    checkOutput("rst_busy",    BusyQnnnH,    0);
                    checkOutput("rst_done",    DoneQnnnH,    0);
                    checkOutput("rst_err",     ErrQnnnH,     0);
                    checkOutput("rst_wordcnt", WordCntQnnnH, 0);
                    checkOutput("rst_rdaddr",  RdAddrQnnnH,  0);
                end
            end
            case (ready_mode)
                0:       TxReadyQnnnH = 1'b1;
                1:       TxReadyQnnnH = (n % 2 == 0);
                default: TxReadyQnnnH = 1'($urandom_range(0, 1));
            endcase

            @(negedge QClk);
            cur = cyc - t0;
            if (cur == 1) err_early = ErrQnnnH;
            if (RdEnQnnnH) begin
                checkOutput("rd_addr", RdAddrQnnnH, s + 16'(4 * rd_cnt));
                rd_cnt++;
            end
            if (stall_prev && !AbortQnnnH && RstQnnnL) begin
                checkOutput("stall_valid", TxValidQnnnH, 1);
                checkOutput("stall_data",  TxDataQnnnH,  prev_data);
            end
            if (TxValidQnnnH) begin
                valid_cnt++;
                if (first_valid_dly < 0) first_valid_dly = cur;
                if (TxReadyQnnnH) obs_bytes.push_back(TxDataQnnnH);
            end
            stall_prev = TxValidQnnnH && !TxReadyQnnnH;
            prev_data  = TxDataQnnnH;
            if (abort_phase == 2 && !rec_abort) begin
                abort_next_valid = int'(TxValidQnnnH);
                rec_abort = 1;
            end
            if (DoneQnnnH) begin
                done_cnt++;
                if (done_dly < 0) done_dly = cur;
                word_cnt_done = WordCntQnnnH;
                err_done      = ErrQnnnH;
            end
            if (done_cnt > 0) begin
                post++;
                busy_end = BusyQnnnH;
                if (post >= 3) finished = 1;
            end
            if (rst_done && post_rst >= 5) finished = 1;
        end
        checkOutput("timeout", finished, 1);
        StartQnnnH = 1'b0;
        AbortQnnnH = 1'b0;
        RstQnnnL   = 1'b1;
    endtask

    // Common checks for a dump that ran to completion at full rate.
    task automatic checkCompleted(input string tag, input bit full_rate);
        compareBytes(tag);
        checkOutput({tag, "_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_wordcnt"},  word_cnt_done, exp_words);
        checkOutput({tag, "_err"},      err_done, exp_err);
        checkOutput({tag, "_rd_cnt"},   rd_cnt, exp_words);
        checkOutput({tag, "_busy_end"}, busy_end, 0);
        if (full_rate)
            checkOutput({tag, "_done_dly"}, done_dly, 2 + exp_words * (2 + BPW));
    endtask

    initial begin
        logic [63:0] lit;
        logic [15:0] rs;
        logic [15:0] re;

        RstQnnnL = 1'b0; StartQnnnH = 1'b0; AbortQnnnH = 1'b0;
        StartAddrQnnnH = '0; EndAddrQnnnH = '0; TxReadyQnnnH = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hAABB_CCDD;

        repeat (3) @(negedge QClk);
        checkOutput("reset_ctrl", {RdEnQnnnH, TxValidQnnnH, BusyQnnnH, DoneQnnnH, ErrQnnnH}, 0);
        checkOutput("reset_data", {TxDataQnnnH, WordCntQnnnH}, 0);
        checkOutput("reset_addr", RdAddrQnnnH, 0);
        @(posedge QClk); #1;
        RstQnnnL = 1'b1;

        $display("[TB] two-word dump at full rate");
        build_expected(16'h0000, 16'h0008);
        applyStimulus(16'h0000, 16'h0008, 0, -1, -1, 0);
        checkCompleted("basic", 1);
        checkOutput("basic_first_valid", first_valid_dly, 4);
`ifndef LOTR_MEM_DUMP_ADDR_HDR_EN
        lit = 64'h1122_3344_AABB_CCDD;
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("basic_lit%0d", i), obs_bytes[i], lit[63-8*i -: 8]);
`endif

        $display("[TB] same range with TxReady toggling");
        applyStimulus(16'h0000, 16'h0008, 1, -1, -1, 0);
        checkCompleted("toggle", 0);

        $display("[TB] empty range");
        build_expected(16'h0010, 16'h0010);
        applyStimulus(16'h0010, 16'h0010, 0, -1, -1, 0);
        checkCompleted("empty", 1);
        checkOutput("empty_valid_cnt", valid_cnt, 0);

        $display("[TB] misaligned start and end");
        build_expected(16'h0012, 16'h0020);
        applyStimulus(16'h0012, 16'h0020, 0, -1, -1, 0);
        checkCompleted("mis_start", 1);
        checkOutput("mis_start_valid_cnt", valid_cnt, 0);
        build_expected(16'h0010, 16'h0023);
        applyStimulus(16'h0010, 16'h0023, 0, -1, -1, 0);
        checkCompleted("mis_end", 1);

        $display("[TB] reversed range, then a legal dump clears Err");
        build_expected(16'h0020, 16'h0010);
        applyStimulus(16'h0020, 16'h0010, 0, -1, -1, 0);
        checkCompleted("reversed", 1);
        build_expected(16'h0000, 16'h0004);
        applyStimulus(16'h0000, 16'h0004, 0, -1, -1, 0);
        checkCompleted("clear", 1);
        checkOutput("clear_err_early", err_early, 0);

        $display("[TB] abort in the third byte of word 1");
        build_expected(16'h0000, 16'h0010);
        while (exp_bytes.size() > BPW + 2) void'(exp_bytes.pop_back());
        applyStimulus(16'h0000, 16'h0010, 0, BPW + 2, -1, 0);
        compareBytes("abort");
        checkOutput("abort_next_valid", abort_next_valid, 0);
        checkOutput("abort_done_cnt",   done_cnt, 1);
        checkOutput("abort_err",        err_done, 1);
        checkOutput("abort_wordcnt",    word_cnt_done, 1);
        checkOutput("abort_rd_cnt",     rd_cnt, 2);

        $display("[TB] reset in the middle of word 1");
        applyStimulus(16'h0000, 16'h0010, 0, -1, BPW + 2, 0);
        checkOutput("reset_mid_done_cnt", done_cnt, 0);
        checkOutput("reset_mid_busy", BusyQnnnH, 0);

        $display("[TB] Start and Abort together in IDLE");
        build_expected(16'h0008, 16'h0010);
        applyStimulus(16'h0008, 16'h0010, 0, -1, -1, 1);
        checkCompleted("start_abort", 1);

`ifdef LOTR_MEM_DUMP_ADDR_HDR_EN
        $display("[TB] address header on a single word");
        mem[1] = 32'hDEAD_BEEF;
        build_expected(16'h0004, 16'h0008);
        applyStimulus(16'h0004, 16'h0008, 0, -1, -1, 0);
        checkCompleted("hdr", 1);
        lit = 64'h0040_0004_DEAD_BEEF;
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("hdr_lit%0d", i), obs_bytes[i], lit[63-8*i -: 8]);
`endif

        $display("[TB] random ranges with random backpressure");
        for (int t = 0; t < 6; t++) begin
            rs = 16'(4 * $urandom_range(0, 200));
            re = rs + 16'(4 * $urandom_range(1, 8));
            build_expected(rs, re);
            applyStimulus(rs, re, 2, -1, -1, 0);
            checkCompleted($sformatf("rand%0d", t), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
